// File: rtl/barrel_pkg.sv
// Shared types and constants for the barrel normalizer.
// Stage table lists the SCAN distances in issue order.
package barrel_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int N_STG  = 5;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [N_STG-1:0][CNT_W-1:0] STAGE_DIST = {
    6'd1, 6'd2, 6'd4, 6'd8, 6'd16
  };

endpackage

// File: rtl/barrel_norm_stage.sv
// One conditional normalize step: shift by i_dist when the
// i_dist bits on the approaching edge are all zero.
module barrel_norm_stage
  import barrel_pkg::*;
(
  input  logic [1:DATA_W]  i_word,
  input  logic [CNT_W-1:0] i_dist,
  input  logic             i_right,
  output logic [1:DATA_W]  o_word,
  output logic             o_taken
);

  logic [1:DATA_W] w_edge;
  logic            w_edge_zero;

  // Isolate the bits that would fall off the end if we shifted.
  always_comb begin
    w_edge = '0;
    if (i_right)
      w_edge = i_word << (DATA_W - int'(i_dist));
    else
      w_edge = i_word >> (DATA_W - int'(i_dist));
  end

  assign w_edge_zero = (w_edge == '0);
  assign o_taken     = w_edge_zero;

  always_comb begin
    o_word = i_word;
    if (w_edge_zero) begin
      if (i_right)
        o_word = i_word >> i_dist;
      else
        o_word = i_word << i_dist;
    end
  end

endmodule

// File: rtl/barrel_normalizer.sv
// Fixed-latency normalizer: one shared stage walks distances
// 16/8/4/2/1 over five SCAN cycles, then holds the result.
module barrel_normalizer
  import barrel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_shift_right,
  input  logic [1:DATA_W]  data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:DATA_W]  shifted_data,
  output logic [CNT_W-1:0] shift_value,
  output logic             is_zero
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  state_t           r_state;
  logic [2:0]       r_step;
  logic [1:DATA_W]  r_word;
  logic [CNT_W-1:0] r_count;
  logic             r_right;
  logic             r_out_valid;
  logic [1:DATA_W]  r_shifted;
  logic [CNT_W-1:0] r_shift_value;
  logic             r_is_zero;

  logic [CNT_W-1:0] w_dist;
  logic [1:DATA_W]  w_word;
  logic             w_taken;
  logic [CNT_W-1:0] w_count;

  assign w_dist = STAGE_DIST[r_step];

  barrel_norm_stage u_stage (
    .i_word  (r_word),
    .i_dist  (w_dist),
    .i_right (r_right),
    .o_word  (w_word),
    .o_taken (w_taken)
  );

  assign w_count = w_taken ? r_count + w_dist : r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_step        <= '0;
      r_word        <= '0;
      r_count       <= '0;
      r_right       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_shifted     <= '0;
      r_shift_value <= '0;
      r_is_zero     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state   <= SCAN;
            r_word    <= data;
            r_right   <= is_shift_right;
            r_step    <= '0;
            r_count   <= '0;
            r_is_zero <= (data == '0);
          end
        end
        SCAN: begin
          r_word  <= w_word;
          r_count <= w_count;
          if (r_step == 3'(N_STG - 1)) begin
            r_state       <= DONE;
            r_out_valid   <= 1'b1;
            r_shifted     <= w_word;
            // All-zero scans only sum to 31; report the full width.
            r_shift_value <= r_is_zero ? FULL : w_count;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = r_out_valid;
  assign shifted_data = r_shifted;
  assign shift_value  = r_shift_value;
  assign is_zero      = r_is_zero;

endmodule

// File: doc/barrel_normalizer.md
BARREL_NORMALIZER -- requirements
Module: barrel_normalizer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits; only 32 is supported.
REQ-002 SHALL have parameter CNT_W, default 6, shift-count width, sized to hold 0..32.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge only.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port is_shift_right  input  1  0 = normalize toward bit 1 (MSB), 1 = toward bit 32 (LSB).
REQ-008 SHALL have port data  input  [1:32]  word to normalize; bit 1 is MSB.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port shifted_data  output  [1:32]  normalized word.
REQ-012 SHALL have port shift_value  output  [CNT_W-1:0]  shift distance applied; shifting back the opposite way by this amount restores data.
REQ-013 SHALL have port is_zero  output  1  captured word was all zeros.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE; in_ready SHALL be 1 exactly in IDLE.
REQ-015 Accept occurs on a rising edge with in_valid=1 in IDLE; data and is_shift_right SHALL be captured then, and later input changes SHALL be ignored until the next accept.
REQ-016 On accept: IDLE->SCAN, step counter=0, count=0, is_zero register = (data==0).
REQ-017 SCAN SHALL run exactly 5 cycles, stage distances 16, 8, 4, 2, 1 in that order.
REQ-018 Left mode stage k: if the top k bits of the working word are zero, shift left by k, zero-fill, count += k.
REQ-019 Right mode stage k: if the bottom k bits are zero, shift right by k, zero-fill, count += k.
REQ-020 After the 5th SCAN edge: state = DONE, out_valid = 1; latency is fixed at 5 cycles from the accept edge, independent of data.
REQ-021 Zero input: full scan still executes (fixed latency); result SHALL be shifted_data = 0, shift_value = 32, is_zero = 1.
REQ-022 Nonzero input: shift_value = leading-zero count (left) or trailing-zero count (right), range 0..31; shifted_data bit 1 = 1 (left) or bit 32 = 1 (right).
REQ-023 In DONE, outputs SHALL be held stable while out_ready = 0; in_valid SHALL be ignored.
REQ-024 DONE with out_ready = 1 on an edge: DONE->IDLE, out_valid = 0; outputs keep last values; no same-edge accept.
REQ-025 Count arithmetic SHALL be unsigned CNT_W-bit and SHALL never wrap.

Reset
REQ-026 While reset = 0: state = IDLE, out_valid = 0, shifted_data = 0, shift_value = 0, is_zero = 0, step = 0; in_ready = 1, but no accept occurs.
REQ-027 Reset asserted mid-SCAN or in DONE SHALL abort the operation immediately (asynchronously); the aborted result SHALL never appear with out_valid = 1.

Structure
REQ-028 Package barrel_pkg SHALL hold DATA_W, CNT_W, the state enum type, and the stage-distance constant table.
REQ-029 One combinational sub-module barrel_norm_stage SHALL implement one conditional shift/count step (inputs: word, distance, direction; outputs: word, taken), instantiated once and reused each SCAN cycle.

Verification
REQ-030 Left, data = 0x0000_1000 -> 5 cycles after accept: out_valid = 1, shifted_data = 0x8000_0000, shift_value = 19, is_zero = 0.
REQ-031 Right, data = 0x0000_0A00 -> shifted_data = 0x0000_0005, shift_value = 9.
REQ-032 Either mode, data = 0 -> shifted_data = 0, shift_value = 32, is_zero = 1, same 5-cycle latency.
REQ-033 Left, data = 0x8000_0001 -> shift_value = 0, shifted_data = 0x8000_0001.
REQ-034 out_ready held 0 for 3 cycles in DONE while in_valid toggles with new data -> outputs stable, in_ready = 0, no accept; IDLE entered on the out_ready = 1 edge.
REQ-035 Reset pulsed during SCAN step 2 -> out_valid stays 0, outputs = 0, in_ready = 1 after release; next request (left, 0x0000_0001) -> shift_value = 31.
